// File: rtl/l3_slice_sa.sv
// l3_slice_sa: set-associative, write-back, write-allocate L3 slice.
// Latency: a hit responds 2 cycles after accept; a miss adds writeback and refill time.
// Backpressure: one request at a time; req_ready_o is high only in IDLE; responses and memory requests hold until accepted.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_*_i / req_ready_o      L2-side request (addr, write, wdata, wstrb)
//   resp_*_o / resp_ready_i    L2-side response (rdata, hit)
//   mem_req_*                  memory request (writeback or refill read)
//   mem_resp_*_i               refill data return
module l3_slice_sa #(
  parameter int SETS   = 256,
  parameter int WAYS   = 4,
  parameter int ADDR_W = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_write_i,
  input  logic [63:0]       req_wdata_i,
  input  logic [7:0]        req_wstrb_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [63:0]       resp_rdata_o,
  output logic              resp_hit_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_req_write_o,
  output logic [63:0]       mem_req_wdata_o,
  input  logic              mem_resp_valid_i,
  input  logic [63:0]       mem_resp_rdata_i
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 3 - IDX_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_WB        = 3'd2;
  localparam logic [2:0] S_FILL_REQ  = 3'd3;
  localparam logic [2:0] S_FILL_WAIT = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  // Storage: tag/data are not reset, valid/dirty/round-robin are.
  logic [TAG_W-1:0] tag_mem  [SETS][WAYS];
  logic [63:0]      data_mem [SETS][WAYS];
  logic [WAYS-1:0]  valid_q  [SETS];
  logic [WAYS-1:0]  dirty_q  [SETS];
  logic [WAY_W-1:0] rr_q     [SETS];

  // Request context and per-transaction state.
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [63:0]       wdata_q;
  logic [7:0]        wstrb_q;
  logic [WAY_W-1:0]  way_q, way_d;
  logic [TAG_W-1:0]  vic_tag_q, vic_tag_d;
  logic [63:0]       vic_data_q, vic_data_d;
  logic              full_q, full_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              hit_q, hit_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic              lk_hit;
  logic [WAY_W-1:0]  lk_hit_way;
  logic              inv_found;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  vic_way;
  logic              hit_wr_en;
  logic              fill_en;
  logic [63:0]       fill_line;
  logic              unused_addr_lsb;

  // The byte offset inside the 64-bit line never matters.
  assign unused_addr_lsb = ^req_addr_i[2:0];

  assign idx     = addr_q[3+IDX_W-1:3];
  assign req_tag = addr_q[ADDR_W-1:3+IDX_W];

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_d,
                                              input logic [63:0] new_d,
                                              input logic [7:0]  strb);
    logic [63:0] r;
    r = old_d;
    for (int b = 0; b < 8; b++) begin
      if (strb[b]) r[8*b +: 8] = new_d[8*b +: 8];
    end
    return r;
  endfunction

  // Tag compare and victim choice for the latched set.
  // Victim: lowest invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    lk_hit     = 1'b0;
    lk_hit_way = '0;
    inv_found  = 1'b0;
    inv_way    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!lk_hit && valid_q[idx][w] && (tag_mem[idx][w] == req_tag)) begin
        lk_hit     = 1'b1;
        lk_hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    vic_way = inv_found ? inv_way : rr_q[idx];
  end

  assign fill_line = write_q ? merge_bytes(mem_resp_rdata_i, wdata_q, wstrb_q)
                             : mem_resp_rdata_i;

  always_comb begin
    state_d    = state_q;
    way_d      = way_q;
    vic_tag_d  = vic_tag_q;
    vic_data_d = vic_data_q;
    full_d     = full_q;
    rdata_d    = rdata_q;
    hit_d      = hit_q;
    hit_wr_en  = 1'b0;
    fill_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (lk_hit) begin
          hit_wr_en = write_q;
          rdata_d   = write_q ? 64'd0 : data_mem[idx][lk_hit_way];
          hit_d     = 1'b1;
          state_d   = S_RESP;
        end else begin
          way_d      = vic_way;
          vic_tag_d  = tag_mem[idx][vic_way];
          vic_data_d = data_mem[idx][vic_way];
          full_d     = !inv_found;
          state_d    = (valid_q[idx][vic_way] && dirty_q[idx][vic_way]) ? S_WB : S_FILL_REQ;
        end
      end
      S_WB: begin
        // Writebacks are posted: acceptance alone completes them.
        if (mem_req_ready_i) state_d = S_FILL_REQ;
      end
      S_FILL_REQ: begin
        if (mem_req_ready_i) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_resp_valid_i) begin
          fill_en = 1'b1;
          rdata_d = write_q ? 64'd0 : mem_resp_rdata_i;
          hit_d   = 1'b0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      way_q      <= '0;
      vic_tag_q  <= '0;
      vic_data_q <= '0;
      full_q     <= 1'b0;
      rdata_q    <= '0;
      hit_q      <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      way_q      <= way_d;
      vic_tag_q  <= vic_tag_d;
      vic_data_q <= vic_data_d;
      full_q     <= full_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      if (state_q == S_IDLE && req_valid_i) begin
        addr_q  <= req_addr_i;
        write_q <= req_write_i;
        wdata_q <= req_wdata_i;
        wstrb_q <= req_wstrb_i;
      end
      // An all-zero strobe on a hit changes nothing, so the line stays clean.
      if (hit_wr_en && (wstrb_q != 8'd0)) dirty_q[idx][lk_hit_way] <= 1'b1;
      if (fill_en) begin
        valid_q[idx][way_q] <= 1'b1;
        dirty_q[idx][way_q] <= write_q;
        // Pointer only advances when a valid line was displaced.
        if (full_q) begin
          rr_q[idx] <= (rr_q[idx] == WAY_W'(WAYS-1)) ? '0 : rr_q[idx] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hit_wr_en) data_mem[idx][lk_hit_way] <= merge_bytes(data_mem[idx][lk_hit_way], wdata_q, wstrb_q);
    if (fill_en) begin
      data_mem[idx][way_q] <= fill_line;
      tag_mem[idx][way_q]  <= req_tag;
    end
  end

  assign req_ready_o     = (state_q == S_IDLE);
  assign resp_valid_o    = (state_q == S_RESP);
  assign resp_rdata_o    = rdata_q;
  assign resp_hit_o      = hit_q;
  assign mem_req_valid_o = (state_q == S_WB) || (state_q == S_FILL_REQ);
  assign mem_req_write_o = (state_q == S_WB);
  assign mem_req_addr_o  = (state_q == S_WB)       ? {vic_tag_q, idx, 3'b000} :
                           (state_q == S_FILL_REQ) ? {req_tag, idx, 3'b000}   : '0;
  assign mem_req_wdata_o = (state_q == S_WB) ? vic_data_q : 64'd0;

endmodule
